// File: rtl/full_subtractor_serial.sv
// Serial subtractor: computes a - b - borrow_in over WIDTH/DIGIT cycles, LSB slice first.
// Results, done and busy are registered; done pulses in the same cycle d/borrow_out/overflow update.
module full_subtractor_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = $clog2(STEPS) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic             a_msb;
    logic             b_msb;
    logic             borrow_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] slice_d;
    logic             slice_bo;
    logic             last_step;

    assign last_step = (cnt == CW'(STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ripple full-subtractor chain across one DIGIT-bit slice.
    always_comb begin : slice_calc
        logic bi;
        slice_d = '0;
        bi      = borrow_r;
        for (int i = 0; i < int'(DIGIT); i++) begin
            slice_d[i] = a_r[i] ^ b_r[i] ^ bi;
            bi         = (~a_r[i] & b_r[i]) | (~(a_r[i] ^ b_r[i]) & bi);
        end
        slice_bo = bi;
    end

    // Operands shift right as slices are consumed; difference slices enter acc from the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            acc        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            borrow_r   <= 1'b0;
            cnt        <= '0;
            d          <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        borrow_r <= borrow_in;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    a_r      <= a_r >> DIGIT;
                    b_r      <= b_r >> DIGIT;
                    borrow_r <= slice_bo;
                    acc      <= (acc >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));
                    cnt      <= cnt + CW'(1);
                end
                DONE: begin
                    d          <= acc;
                    borrow_out <= borrow_r;
                    overflow   <= (a_msb != b_msb) && (acc[WIDTH-1] != a_msb);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_full_subtractor_serial.sv
// Directed bench for full_subtractor_serial: a bit-serial instance (DIGIT=1) and a nibble-serial instance (DIGIT=4).
module tb_full_subtractor_serial;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    typedef struct packed {
        logic x;
        logic y;
        logic bi;
        logic diff;
        logic bo;
    } bit_vec_t;

    logic       clk;
    logic       rst;
    logic       start1;
    logic       start4;
    logic [7:0] a;
    logic [7:0] b;
    logic       borrow_in;
    logic       busy1, done1, bo1, ov1;
    logic [7:0] d1;
    logic       busy4, done4, bo4, ov4;
    logic [7:0] d4;

    int n_checks = 0;
    int n_fail   = 0;

    full_subtractor_serial #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .borrow_in(borrow_in),
        .busy(busy1), .done(done1), .d(d1), .borrow_out(bo1), .overflow(ov1)
    );

    full_subtractor_serial #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .borrow_in(borrow_in),
        .busy(busy4), .done(done4), .d(d4), .borrow_out(bo4), .overflow(ov4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation; latency counts edges from the accepting edge to the first done sample.
    task automatic do_op(input bit use4, input logic [7:0] ta, input logic [7:0] tb_, input logic tbi,
                         output int lat, output int busy_cnt,
                         output logic [7:0] rd, output logic rbo, output logic rov);
        @(negedge clk);
        a = ta; b = tb_; borrow_in = tbi;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0; start4 = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!(use4 ? done4 : done1) && lat < 40) begin
            if (use4 ? busy4 : busy1) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        rd  = use4 ? d4  : d1;
        rbo = use4 ? bo4 : bo1;
        rov = use4 ? ov4 : ov1;
    endtask

    initial begin
        vec_t       vecs[9];
        bit_vec_t   bits[8];
        int         lat, bcnt, pulses;
        int         p[3];
        int         np;
        logic [7:0] rd, dsave;
        logic       rbo, rov;

        vecs[0] = '{a: 8'h05, b: 8'h03, bi: 1'b0, d: 8'h02, bo: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, bi: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h00, bi: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h01, bi: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
        vecs[4] = '{a: 8'h7F, b: 8'hFF, bi: 1'b0, d: 8'h80, bo: 1'b1, ov: 1'b1};
        vecs[5] = '{a: 8'h3C, b: 8'h1E, bi: 1'b0, d: 8'h1E, bo: 1'b0, ov: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, bi: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        vecs[7] = '{a: 8'hA5, b: 8'h5A, bi: 1'b1, d: 8'h4A, bo: 1'b0, ov: 1'b1};
        vecs[8] = '{a: 8'h10, b: 8'h20, bi: 1'b0, d: 8'hF0, bo: 1'b1, ov: 1'b0};

        bits[0] = '{x: 1'b0, y: 1'b0, bi: 1'b0, diff: 1'b0, bo: 1'b0};
        bits[1] = '{x: 1'b0, y: 1'b0, bi: 1'b1, diff: 1'b1, bo: 1'b1};
        bits[2] = '{x: 1'b0, y: 1'b1, bi: 1'b0, diff: 1'b1, bo: 1'b1};
        bits[3] = '{x: 1'b0, y: 1'b1, bi: 1'b1, diff: 1'b0, bo: 1'b1};
        bits[4] = '{x: 1'b1, y: 1'b0, bi: 1'b0, diff: 1'b1, bo: 1'b0};
        bits[5] = '{x: 1'b1, y: 1'b0, bi: 1'b1, diff: 1'b0, bo: 1'b0};
        bits[6] = '{x: 1'b1, y: 1'b1, bi: 1'b0, diff: 1'b0, bo: 1'b0};
        bits[7] = '{x: 1'b1, y: 1'b1, bi: 1'b1, diff: 1'b1, bo: 1'b1};

        rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
        a = 8'h00; b = 8'h00; borrow_in = 1'b0;

        #12;
        check("reset_busy1", 64'(busy1), 64'd0);
        check("reset_done1", 64'(done1), 64'd0);
        check("reset_d1",    64'(d1),    64'd0);
        check("reset_bo1",   64'(bo1),   64'd0);
        check("reset_ov1",   64'(ov1),   64'd0);
        check("reset_busy4", 64'(busy4), 64'd0);
        check("reset_done4", 64'(done4), 64'd0);
        check("reset_d4",    64'(d4),    64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].bi, lat, bcnt, rd, rbo, rov);
            check($sformatf("vec%0d_d", i),   64'(rd),  64'(vecs[i].d));
            check($sformatf("vec%0d_bo", i),  64'(rbo), 64'(vecs[i].bo));
            check($sformatf("vec%0d_ov", i),  64'(rov), 64'(vecs[i].ov));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd9);
            if (i == 0) check("vec0_busy_cycles", 64'(bcnt), 64'd8);
        end

        // Single-bit slice truth table; upper bits of d replicate the borrow.
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, {7'h00, bits[i].x}, {7'h00, bits[i].y}, bits[i].bi, lat, bcnt, rd, rbo, rov);
            check($sformatf("tt%0d_diff", i),  64'(rd[0]),   64'(bits[i].diff));
            check($sformatf("tt%0d_upper", i), 64'(rd[7:1]), bits[i].bo ? 64'h7F : 64'h00);
            check($sformatf("tt%0d_bo", i),    64'(rbo),     64'(bits[i].bo));
        end

        do_op(1'b1, 8'h3C, 8'h1E, 1'b0, lat, bcnt, rd, rbo, rov);
        check("d4_lat",  64'(lat), 64'd3);
        check("d4_d",    64'(rd),  64'h1E);
        check("d4_busy", 64'(bcnt), 64'd2);

        // Start and operand changes during RUN are ignored.
        @(negedge clk);
        a = 8'h05; b = 8'h03; borrow_in = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'h11; borrow_in = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        pulses = 0; dsave = 8'h00;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                pulses++;
                dsave = d1;
            end
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_d",      64'(dsave),  64'h02);

        // Asynchronous reset on RUN cycle 4 aborts the operation.
        @(negedge clk);
        a = 8'h3C; b = 8'h1E; borrow_in = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", 64'(busy1), 64'd1);
        check("abort_d_before",    64'(d1),    64'h02);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy1), 64'd0);
        check("abort_done", 64'(done1), 64'd0);
        check("abort_d",    64'(d1),    64'd0);
        check("abort_bo",   64'(bo1),   64'd0);
        check("abort_ov",   64'(ov1),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done1) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        do_op(1'b0, 8'h05, 8'h03, 1'b0, lat, bcnt, rd, rbo, rov);
        check("post_abort_d",   64'(rd),  64'h02);
        check("post_abort_lat", 64'(lat), 64'd9);

        // Held start restarts every STEPS+2 cycles.
        @(negedge clk);
        a = 8'h3C; b = 8'h1E; borrow_in = 1'b0; start4 = 1'b1;
        np = 0; p[0] = 0; p[1] = 0; p[2] = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done4 && np < 3) begin
                p[np] = c;
                np++;
                check($sformatf("held_d%0d", np), 64'(d4), 64'h1E);
            end
        end
        start4 = 1'b0;
        check("held_pulses", 64'(np),          64'd3);
        check("held_first",  64'(p[0]),        64'd3);
        check("held_gap1",   64'(p[1] - p[0]), 64'd4);
        check("held_gap2",   64'(p[2] - p[1]), 64'd4);
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
